battleship_turn_ctrl: RTL

Parametrised battleship game controller, next generation of the turn FSM. Sequences ship-count setup, player and PC turns, board-memory query handshakes, per-side hit counting, victory detection and a seconds-based turn timer. It sits between the debounced button/switch inputs, the board memory and the display logic.

---
 rtl/battleship_turn_ctrl.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/battleship_turn_ctrl.sv
// battleship_turn_ctrl: setup, alternating player/PC turns, board-query handshake, hit counting, victory, turn timer.
// Latency: btn to q_req 1 cycle; q_ack to hit counter 1 cycle; winning q_ack to game_over 2 cycles.
// Backpressure: q_req held with stable q_x/q_y/q_side until q_ack; btn is ignored outside SETUP, P_TURN and OVER.
// Optional feature: define BATTLESHIP_BONUS_SHOT_EN so a non-winning hit grants the same side another shot.
module battleship_turn_ctrl #(
  parameter int BOARD_N     = 5,
  parameter int MAX_SHIPS   = 5,
  parameter int CYC_PER_SEC = 50_000_000,
  parameter int TURN_SECS   = 15,
  localparam int CW = $clog2(BOARD_N),
  localparam int SW = $clog2(MAX_SHIPS + 1),
  localparam int HW = $clog2(MAX_SHIPS * (MAX_SHIPS + 1) / 2 + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn,
  input  logic [SW-1:0] ship_sel,
  input  logic [CW-1:0] cur_x,
  input  logic [CW-1:0] cur_y,
  input  logic [CW-1:0] rng_x,
  input  logic [CW-1:0] rng_y,
  input  logic          q_ack,
  input  logic          q_hit,
  input  logic          q_used,
  output logic          q_req,
  output logic          q_side,
  output logic [CW-1:0] q_x,
  output logic [CW-1:0] q_y,
  output logic [2:0]    state,
  output logic          turn,
  output logic [SW-1:0] n_ships,
  output logic [HW-1:0] hits_p,
  output logic [HW-1:0] hits_pc,
  output logic [7:0]    secs_left,
  output logic          timeout,
  output logic          game_over,
  output logic          winner
);

  typedef enum logic [2:0] {
    SETUP    = 3'd0,
    P_TURN   = 3'd1,
    P_QUERY  = 3'd2,
    P_CHECK  = 3'd3,
    PC_TURN  = 3'd4,
    PC_QUERY = 3'd5,
    PC_CHECK = 3'd6,
    OVER     = 3'd7
  } state_t;

  localparam int              PSW       = (CYC_PER_SEC > 1) ? $clog2(CYC_PER_SEC) : 1;
  localparam logic [CW:0]     BOARD_LIM = (CW + 1)'(BOARD_N);
  localparam logic [SW:0]     SHIP_LIM  = (SW + 1)'(MAX_SHIPS);
  localparam logic [PSW-1:0]  PRESC_TOP = PSW'(CYC_PER_SEC - 1);
  localparam logic [7:0]      SECS_TOP  = 8'(TURN_SECS);

  state_t          st_q, st_d;
  logic [SW-1:0]   n_ships_q;
  logic [HW-1:0]   target_q, target_d;
  logic [HW-1:0]   hits_p_q, hits_pc_q;
  logic [7:0]      secs_q;
  logic [PSW-1:0]  presc_q;
  logic [CW-1:0]   qx_q, qy_q;
  logic            qside_q, timeout_q, winner_q;
`ifdef BATTLESHIP_BONUS_SHOT_EN
  logic            last_hit_q;
`endif

  logic sel_ok, cur_ok, rng_ok, expire;
  logic start, reload, tick, shoot_p, shoot_pc, inc_p, inc_pc, fire_to, win_p, win_pc, clear;

  // Range qualifiers for the operator inputs and the timer expiry condition.
  always_comb begin
    sel_ok = (ship_sel != '0) && ({1'b0, ship_sel} <= SHIP_LIM);
    cur_ok = ({1'b0, cur_x} < BOARD_LIM) && ({1'b0, cur_y} < BOARD_LIM);
    rng_ok = ({1'b0, rng_x} < BOARD_LIM) && ({1'b0, rng_y} < BOARD_LIM);
    expire = (presc_q == '0) && (secs_q == 8'd1);
  end

  // Total ship cells for the requested count: 1 + 2 + ... + n.
  always_comb begin
    target_d = '0;
    for (int i = 1; i <= MAX_SHIPS; i++) begin
      if (i <= int'(ship_sel)) target_d = target_d + HW'(i);
    end
  end

  // Next-state logic and one-cycle control strobes for the datapath.
  always_comb begin
    st_d     = st_q;
    start    = 1'b0;
    reload   = 1'b0;
    tick     = 1'b0;
    shoot_p  = 1'b0;
    shoot_pc = 1'b0;
    inc_p    = 1'b0;
    inc_pc   = 1'b0;
    fire_to  = 1'b0;
    win_p    = 1'b0;
    win_pc   = 1'b0;
    clear    = 1'b0;
    case (st_q)
      SETUP: begin
        if (btn && sel_ok) begin
          start  = 1'b1;
          reload = 1'b1;
          st_d   = P_TURN;
        end
      end
      P_TURN: begin
        if (btn && cur_ok) begin
          // A shot taken on the expiry cycle freezes the timer so expiry is not lost.
          shoot_p = 1'b1;
          tick    = !expire;
          st_d    = P_QUERY;
        end else begin
          tick = 1'b1;
          if (expire) begin
            fire_to = 1'b1;
            st_d    = PC_TURN;
          end
        end
      end
      P_QUERY: begin
        if (q_ack) begin
          if (q_used) begin
            st_d = P_TURN;
          end else begin
            inc_p = q_hit;
            st_d  = P_CHECK;
          end
        end
      end
      P_CHECK: begin
        if (hits_p_q == target_q) begin
          win_p = 1'b1;
          st_d  = OVER;
        end
`ifdef BATTLESHIP_BONUS_SHOT_EN
        else if (last_hit_q) begin
          reload = 1'b1;
          st_d   = P_TURN;
        end
`endif
        else begin
          st_d = PC_TURN;
        end
      end
      PC_TURN: begin
        if (rng_ok) begin
          shoot_pc = 1'b1;
          st_d     = PC_QUERY;
        end
      end
      PC_QUERY: begin
        if (q_ack) begin
          if (q_used) begin
            st_d = PC_TURN;
          end else begin
            inc_pc = q_hit;
            st_d   = PC_CHECK;
          end
        end
      end
      PC_CHECK: begin
        if (hits_pc_q == target_q) begin
          win_pc = 1'b1;
          st_d   = OVER;
        end
`ifdef BATTLESHIP_BONUS_SHOT_EN
        else if (last_hit_q) begin
          st_d = PC_TURN;
        end
`endif
        else begin
          reload = 1'b1;
          st_d   = P_TURN;
        end
      end
      OVER: begin
        if (btn) begin
          clear = 1'b1;
          st_d  = SETUP;
        end
      end
      default: st_d = SETUP;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= SETUP;
    else      st_q <= st_d;
  end

  // Ship count and hit target are latched once per game at setup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_ships_q <= '0;
      target_q  <= '0;
    end else if (start) begin
      n_ships_q <= ship_sel;
      target_q  <= target_d;
    end
  end

  // Query coordinates and side, captured when a shot is launched and held through the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qx_q    <= '0;
      qy_q    <= '0;
      qside_q <= 1'b0;
    end else if (shoot_p) begin
      qx_q    <= cur_x;
      qy_q    <= cur_y;
      qside_q <= 1'b0;
    end else if (shoot_pc) begin
      qx_q    <= rng_x;
      qy_q    <= rng_y;
      qside_q <= 1'b1;
    end
  end

  // Turn timer: prescaler counts cycles, secs_left counts whole seconds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      secs_q  <= '0;
      presc_q <= '0;
    end else if (reload) begin
      secs_q  <= SECS_TOP;
      presc_q <= PRESC_TOP;
    end else if (tick) begin
      if (presc_q == '0) begin
        presc_q <= PRESC_TOP;
        secs_q  <= secs_q - 8'd1;
      end else begin
        presc_q <= presc_q - PSW'(1);
      end
    end
  end

  // Per-side hit counters, cleared at setup and on restart.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_p_q  <= '0;
      hits_pc_q <= '0;
    end else if (start || clear) begin
      hits_p_q  <= '0;
      hits_pc_q <= '0;
    end else begin
      if (inc_p)  hits_p_q  <= hits_p_q + HW'(1);
      if (inc_pc) hits_pc_q <= hits_pc_q + HW'(1);
    end
  end

  // Timeout pulse and winner flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_q <= 1'b0;
      winner_q  <= 1'b0;
    end else begin
      timeout_q <= fire_to;
      if (clear)       winner_q <= 1'b0;
      else if (win_pc) winner_q <= 1'b1;
      else if (win_p)  winner_q <= 1'b0;
    end
  end

`ifdef BATTLESHIP_BONUS_SHOT_EN
  // Remembers whether the last valid shot hit, deciding who shoots next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_hit_q <= 1'b0;
    end else if ((st_q == P_QUERY || st_q == PC_QUERY) && q_ack && !q_used) begin
      last_hit_q <= q_hit;
    end
  end
`endif

  assign q_req     = (st_q == P_QUERY) || (st_q == PC_QUERY);
  assign q_side    = qside_q;
  assign q_x       = qx_q;
  assign q_y       = qy_q;
  assign state     = st_q;
  assign turn      = (st_q == PC_TURN) || (st_q == PC_QUERY) || (st_q == PC_CHECK);
  assign n_ships   = n_ships_q;
  assign hits_p    = hits_p_q;
  assign hits_pc   = hits_pc_q;
  assign secs_left = secs_q;
  assign timeout   = timeout_q;
  assign game_over = (st_q == OVER);
  assign winner    = winner_q;

endmodule
